timer_ctrl: RTL and testbench

- Control stage sitting directly upstream of the team's loadable n-bit up-counter.
- Drives the counter's load, enable and load-data inputs, and reads its count back.
- Provides a programmable one-shot or periodic timer with a clock prescaler.
- Emits a one-cycle tick on each expiry; the tick goes to the interrupt/event logic.

---
 rtl/timer_ctrl.sv | 141 ++++++++++++++
 tb/tb_timer_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - one-shot/periodic timer with prescaler driving a loadable up-counter
// Optional expiry counter output exp_count enabled by defining TIMER_CTRL_EXP_CNT_EN.
module timer_ctrl #(
  parameter int N = 8,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic [N-1:0] period,
  input  logic [P-1:0] prescale,
  input  logic [N-1:0] count_in,
  output logic         cnt_load,
  output logic [N-1:0] cnt_load_data,
  output logic         cnt_en,
  output logic         busy,
  output logic         tick
`ifdef TIMER_CTRL_EXP_CNT_EN
  ,
  output logic [7:0]   exp_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RUN    = 2'd2,
    S_EXPIRE = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_period_q;
  logic [P-1:0] r_prescale_q;
  logic         r_periodic_q;
  logic [P-1:0] r_pre_cnt;

  logic w_arm_req;
  logic w_match;
  logic w_pre_hit;

  // A zero period would never expire meaningfully, so such a start is dropped.
  assign w_arm_req = (r_state == S_IDLE) && start && (period != '0);
  // >= rather than == so an externally loaded counter past the limit still expires.
  assign w_match   = (count_in >= r_period_q);
  assign w_pre_hit = (r_pre_cnt == r_prescale_q);

  assign cnt_load_data = '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; reset forces the counter interface quiet.
  always_comb begin
    w_next   = r_state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    busy     = 1'b1;
    tick     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_arm_req) begin
          w_next = S_ARM;
        end
      end
      S_ARM: begin
        cnt_load = 1'b1;
        w_next   = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        cnt_en = w_pre_hit && !w_match;
        if (stop) begin
          w_next = S_IDLE;
        end else if (w_match) begin
          w_next = S_EXPIRE;
        end
      end
      S_EXPIRE: begin
        tick   = 1'b1;
        w_next = (r_periodic_q && !stop) ? S_ARM : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (reset) begin
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      busy     = 1'b0;
      tick     = 1'b0;
    end
  end

  // Shadow capture on arming and prescaler divide-by-(prescale+1).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period_q   <= '0;
      r_prescale_q <= '0;
      r_periodic_q <= 1'b0;
      r_pre_cnt    <= '0;
    end else begin
      if (w_arm_req) begin
        r_period_q   <= period;
        r_prescale_q <= prescale;
        r_periodic_q <= periodic;
      end
      case (r_state)
        S_ARM:   r_pre_cnt <= '0;
        S_RUN:   r_pre_cnt <= w_pre_hit ? '0 : r_pre_cnt + P'(1);
        default: r_pre_cnt <= r_pre_cnt;
      endcase
    end
  end

`ifdef TIMER_CTRL_EXP_CNT_EN
  logic [7:0] r_exp_count;

  // Saturating count of expiries since the last arm from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp_count <= 8'd0;
    end else if (w_arm_req) begin
      r_exp_count <= 8'd0;
    end else if ((r_state == S_EXPIRE) && (r_exp_count != 8'hFF)) begin
      r_exp_count <= r_exp_count + 8'd1;
    end
  end

  assign exp_count = r_exp_count;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl with a behavioural counter
module tb_timer_ctrl;
  localparam int N = 8;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         periodic;
  logic [N-1:0] period;
  logic [P-1:0] prescale;
  logic [N-1:0] count_in;
  logic         cnt_load;
  logic [N-1:0] cnt_load_data;
  logic         cnt_en;
  logic         busy;
  logic         tick;
`ifdef TIMER_CTRL_EXP_CNT_EN
  logic [7:0]   exp_count;
`endif

  logic [N-1:0] r_cnt;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [3:0]   exp_q[$];

  always #5 clk = ~clk;

  timer_ctrl #(.N(N), .P(P)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .periodic(periodic),
    .period(period),
    .prescale(prescale),
    .count_in(count_in),
    .cnt_load(cnt_load),
    .cnt_load_data(cnt_load_data),
    .cnt_en(cnt_en),
    .busy(busy),
    .tick(tick)
`ifdef TIMER_CTRL_EXP_CNT_EN
    ,
    .exp_count(exp_count)
`endif
  );

  // Downstream loadable up-counter, one cycle latency.
  always @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (cnt_load) r_cnt <= cnt_load_data;
    else if (cnt_en) r_cnt <= r_cnt + N'(1);
  end
  assign count_in = r_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {cnt_load, cnt_en, tick, busy} in cycle c after start sampled at cycle 0.
  function automatic logic [3:0] exp_at(int c, int p, int s, bit per, int cut);
    int t, m, k, run_len;
    logic [3:0] r;
    r = 4'b0000;
    if (p == 0 || c < 1 || c > cut) return r;
    run_len = p * (s + 1);
    t = run_len + 3;
    m = (c - 1) / t;
    k = (c - 1) % t;
    if (!per && m > 0) return r;
    if (k == 0) r = 4'b1001;
    else if (k <= run_len + 1) begin
      r = 4'b0001;
      if ((k - 1) < run_len && ((k - 1) % (s + 1)) == s) r = 4'b0101;
    end else r = 4'b0011;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_case(input string name, input int p, input int s, input bit per,
                          input int ncyc, input int stop_at, input int reset_at,
                          input int inj_at, input bit start_stop);
    int cut;
    logic [3:0] e;
    cut = 1 << 30;
    if (stop_at >= 0) cut = stop_at;
    else if (reset_at >= 0) cut = reset_at - 1;
    for (int c = 1; c <= ncyc; c++) exp_q.push_back(exp_at(c, p, s, per, cut));
    start = 1'b1;
    stop = start_stop;
    period = N'(p);
    prescale = P'(s);
    periodic = per;
    #1;
    check_eq($sformatf("%s:c0", name), 32'({cnt_load, cnt_en, tick, busy}), 32'd0);
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start = 1'b0;
      stop = (c == stop_at);
      reset = (reset_at >= 0) && (c >= reset_at) && (c < reset_at + 3);
      period = N'($urandom);
      prescale = P'($urandom);
      periodic = 1'($urandom);
      if (c == inj_at) begin
        start = 1'b1;
        period = N'(p + 2);
      end
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("%s:c%0d", name, c), 32'({cnt_load, cnt_en, tick, busy}), 32'(e));
      if (c == 1) check_eq($sformatf("%s:ld_data", name), 32'(cnt_load_data), 32'd0);
    end
    step();
    start = 1'b0;
    reset = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    #1;
    check_eq($sformatf("%s:quiet", name), 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    periodic = 1'b0;
    period = '0;
    prescale = '0;
    repeat (3) step();
    #1;
    check_eq("reset_outs", 32'({cnt_load, cnt_en, tick, busy}), 32'd0);
    check_eq("reset_ld_data", 32'(cnt_load_data), 32'd0);
    reset = 1'b0;
    step();

    run_case("oneshot_p3", 3, 0, 1'b0, 10, -1, -1, -1, 1'b0);
    run_case("periodic_p3s1", 3, 1, 1'b1, 30, -1, -1, -1, 1'b0);
    run_case("stop_at_match", 5, 0, 1'b1, 12, 7, -1, -1, 1'b0);
    run_case("period_zero", 0, 0, 1'b1, 5, -1, -1, -1, 1'b0);
    run_case("start_busy", 4, 2, 1'b0, 18, -1, -1, 5, 1'b1);
    run_case("reset_mid_run", 5, 1, 1'b0, 14, -1, 6, -1, 1'b0);
    run_case("stop_in_expire", 2, 0, 1'b1, 10, 5, -1, -1, 1'b0);
    run_case("prescale_max", 2, 255, 1'b0, 520, -1, -1, -1, 1'b0);

`ifdef TIMER_CTRL_EXP_CNT_EN
    start = 1'b1;
    period = N'(1);
    prescale = '0;
    periodic = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      step();
      start = 1'b0;
    end
    #1;
    check_eq("exp_cnt_10", 32'(exp_count), 32'd10);
    repeat (1200) step();
    #1;
    check_eq("exp_cnt_sat", 32'(exp_count), 32'd255);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    step();
    #1;
    check_eq("exp_cnt_idle_busy", 32'(busy), 32'd0);
    check_eq("exp_cnt_idle_hold", 32'(exp_count), 32'd255);
    start = 1'b1;
    period = N'(1);
    step();
    start = 1'b0;
    #1;
    check_eq("exp_cnt_clear", 32'(exp_count), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
